ps2_mouse_packet: RTL

- Consumes the byte stream from the PS/2 receiver stage (rx_done_tick, dout) and assembles standard 3-byte PS/2 mouse packets.
- Decodes buttons, 9-bit signed X/Y deltas and overflow flags.
- Maintains a saturating absolute cursor position for the display logic downstream.
- Resynchronises on framing errors and on inter-byte timeouts.

---
 rtl/ps2_mouse_packet.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte PS/2 mouse packets from the receiver byte stream, decodes
// buttons/deltas/overflow and tracks a clamped absolute cursor position.
module ps2_mouse_packet #(
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int POS_W       = 10,
    parameter int TIMEOUT_CYC = 100000,
    parameter int TO_W        = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_done_tick,
    input  logic [7:0]       rx_data,
    output logic [2:0]       btn,
    output logic [8:0]       xm,
    output logic [8:0]       ym,
    output logic             x_ovf,
    output logic             y_ovf,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic             m_done_tick,
    output logic             frame_err_tick
);

    typedef enum logic [1:0] {WAIT0, WAIT1, WAIT2, UPDATE} state_t;

    localparam int SW = POS_W + 2;
    localparam logic [TO_W-1:0]      TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic signed [SW-1:0] X_MAX_S = SW'(X_MAX);
    localparam logic signed [SW-1:0] Y_MAX_S = SW'(Y_MAX);

    state_t           state_q, state_d;
    logic [6:0]       hdr_q, hdr_d;       // byte0 without its always-one bit 3
    logic [7:0]       byte1_q, byte1_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [2:0]       btn_q, btn_d;
    logic [8:0]       xm_q, xm_d, ym_q, ym_d;
    logic             x_ovf_q, x_ovf_d, y_ovf_q, y_ovf_d;
    logic [POS_W-1:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
    logic             m_done_q, m_done_d, ferr_q, ferr_d, ferr_pend_q, ferr_pend_d;
    logic signed [SW-1:0] x_sum, y_sum;

    function automatic logic [POS_W-1:0] clamp(input logic signed [SW-1:0] v,
                                               input logic signed [SW-1:0] mx);
        if (v < 0)
            return '0;
        else if (v > mx)
            return mx[POS_W-1:0];
        else
            return v[POS_W-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        byte1_d     = byte1_q;
        to_cnt_d    = '0;
        btn_d       = btn_q;
        xm_d        = xm_q;
        ym_d        = ym_q;
        x_ovf_d     = x_ovf_q;
        y_ovf_d     = y_ovf_q;
        x_pos_d     = x_pos_q;
        y_pos_d     = y_pos_q;
        m_done_d    = 1'b0;
        ferr_d      = ferr_pend_q;
        ferr_pend_d = 1'b0;
        x_sum = signed'({2'b00, x_pos_q}) + signed'({{(SW-9){xm_q[8]}}, xm_q});
        y_sum = signed'({2'b00, y_pos_q}) - signed'({{(SW-9){ym_q[8]}}, ym_q});

        case (state_q)
            WAIT0: begin
                if (rx_done_tick) begin
                    if (rx_data[3]) begin
                        hdr_d   = {rx_data[7:4], rx_data[2:0]};
                        state_d = WAIT1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            WAIT1: begin
                if (rx_done_tick) begin
                    byte1_d = rx_data;
                    state_d = WAIT2;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = WAIT0;
                    ferr_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WAIT2: begin
                if (rx_done_tick) begin
                    btn_d   = hdr_q[2:0];
                    xm_d    = {hdr_q[3], byte1_q};
                    ym_d    = {hdr_q[4], rx_data};
                    x_ovf_d = hdr_q[5];
                    y_ovf_d = hdr_q[6];
                    state_d = UPDATE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = WAIT0;
                    ferr_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            UPDATE: begin
                if (!x_ovf_q) x_pos_d = clamp(x_sum, X_MAX_S);
                if (!y_ovf_q) y_pos_d = clamp(y_sum, Y_MAX_S);
                m_done_d = 1'b1;
                state_d  = WAIT0;
                // A bad header here would pulse alongside m_done; push its error one cycle later.
                if (rx_done_tick) begin
                    if (rx_data[3]) begin
                        hdr_d   = {rx_data[7:4], rx_data[2:0]};
                        state_d = WAIT1;
                    end else begin
                        ferr_pend_d = 1'b1;
                    end
                end
            end
            default: state_d = WAIT0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT0;
            hdr_q       <= '0;
            byte1_q     <= '0;
            to_cnt_q    <= '0;
            btn_q       <= '0;
            xm_q        <= '0;
            ym_q        <= '0;
            x_ovf_q     <= 1'b0;
            y_ovf_q     <= 1'b0;
            x_pos_q     <= POS_W'(X_MAX / 2);
            y_pos_q     <= POS_W'(Y_MAX / 2);
            m_done_q    <= 1'b0;
            ferr_q      <= 1'b0;
            ferr_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            byte1_q     <= byte1_d;
            to_cnt_q    <= to_cnt_d;
            btn_q       <= btn_d;
            xm_q        <= xm_d;
            ym_q        <= ym_d;
            x_ovf_q     <= x_ovf_d;
            y_ovf_q     <= y_ovf_d;
            x_pos_q     <= x_pos_d;
            y_pos_q     <= y_pos_d;
            m_done_q    <= m_done_d;
            ferr_q      <= ferr_d;
            ferr_pend_q <= ferr_pend_d;
        end
    end

    assign btn            = btn_q;
    assign xm             = xm_q;
    assign ym             = ym_q;
    assign x_ovf          = x_ovf_q;
    assign y_ovf          = y_ovf_q;
    assign x_pos          = x_pos_q;
    assign y_pos          = y_pos_q;
    assign m_done_tick    = m_done_q;
    assign frame_err_tick = ferr_q;

endmodule
